imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_pkg.sv | 6 +
 rtl/imem_byte_ser.sv | 28 ++
 rtl/imem_loader.sv | 100 ++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory loader
package imem_pkg;
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WRITE, S_RUN, S_ERROR} state_e;
   localparam int MEM_BYTES_DEFAULT = 1024;
   localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_byte_ser.sv
// imem_byte_ser: splits a 32-bit word into four bytes, MSB first
module imem_byte_ser (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        en_i,
   input  logic [31:0] data_i,
   output logic [1:0]  idx_o,
   output logic [7:0]  byte_o,
   output logic        last_o
);
   logic [31:0] data_q;
   logic [1:0]  idx_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         data_q <= '0;
         idx_q  <= '0;
      end else if (load_i) begin
         data_q <= data_i;
         idx_q  <= '0;
      end else if (en_i) begin
         idx_q  <= idx_q + 2'd1;
      end
   // index 0 selects bits 31:24 so the MSB lands at the lowest address
   assign byte_o = 8'(data_q >> {~idx_q, 3'b000});
   assign idx_o  = idx_q;
   assign last_o = &idx_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams host words into byte-wide instruction memory, then releases the CPU
module imem_loader
   import imem_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
   parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              wr_valid,
   input  logic [31:0]       wr_data,
   input  logic              wr_last,
   output logic              wr_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_run,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-2:0] word_count
);
   localparam int WC_W = ADDR_W - 1;
   state_e            state_q, state_d;
   logic [ADDR_W:0]   ptr_q, ptr_d, ptr_nxt;
   logic [WC_W-1:0]   wc_q, wc_d;
   logic              last_q, last_d, done_q, done_d;
   logic              accept, ser_last;
   logic [1:0]        idx;
   logic [7:0]        ser_byte;

   // one spare pointer bit lets a full memory read as MEM_BYTES instead of wrapping
   assign ptr_nxt = ptr_q + (ADDR_W+1)'(BYTES_PER_WORD);
   assign wr_ready = state_q == S_WAIT;
   assign accept = wr_valid && wr_ready;

   imem_byte_ser u_ser (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (accept),
      .en_i   (state_q == S_WRITE),
      .data_i (wr_data),
      .idx_o  (idx),
      .byte_o (ser_byte),
      .last_o (ser_last)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         wc_q    <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         wc_q    <= wc_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      wc_d    = wc_q;
      last_d  = last_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE, S_RUN, S_ERROR:
            if (start) begin
               state_d = S_WAIT;
               ptr_d   = '0;
               wc_d    = '0;
            end
         S_WAIT:
            if (wr_valid) begin
               state_d = S_WRITE;
               last_d  = wr_last;
            end
         S_WRITE:
            if (ser_last) begin
               ptr_d   = ptr_nxt;
               wc_d    = wc_q + WC_W'(1);
               done_d  = last_q;
               state_d = last_q ? S_RUN
                       : (ptr_nxt == (ADDR_W+1)'(MEM_BYTES)) ? S_ERROR : S_WAIT;
            end
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_we     = state_q == S_WRITE;
   assign mem_waddr  = mem_we ? ptr_q[ADDR_W-1:0] + ADDR_W'(idx) : '0;
   assign mem_wdata  = mem_we ? ser_byte : '0;
   assign cpu_run    = state_q == S_RUN;
   assign err        = state_q == S_ERROR;
   assign done       = done_q;
   assign word_count = wc_q;
endmodule
